// File: rtl/mtm_alu_core_seq.sv
// ---------------------------------------------------------------------------
// mtm_alu_core_seq
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures the operand set; stage 2 captures the computed result,
// flags and illegal-opcode indication.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset, empties both stages
//   in_valid   : operand set A/B/opmode present this cycle
//   in_ready   : block can accept an operand set this cycle
//   A, B       : operands, WIDTH bits
//   opmode     : 000 AND, 001 OR, 100 ADD, 101 SUB, anything else illegal
//   out_valid  : C/flags/err_op hold a valid result
//   out_ready  : consumer takes the result this cycle
//   C          : result, WIDTH bits
//   flags      : {carry, overflow, zero, negative}
//   err_op     : result came from a transaction with an illegal opmode
// ---------------------------------------------------------------------------
module mtm_alu_core_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       opmode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic [3:0]       flags,
   output logic             err_op
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_c;
   logic [3:0]       s2_flags;
   logic             s2_err;

   logic             advance;
   logic             s1_load;
   logic             in_fire;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] res_c;
   logic             res_carry;
   logic             res_ovf;
   logic             res_err;
   logic [3:0]       res_flags;

   // Stage 2 may take new data when it is empty or its content is being
   // consumed; stage 1 moves on the same condition. Stage 1 can also refill
   // while stage 2 stalls, as long as stage 1 itself is empty.
   assign advance  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || advance;
   assign in_ready = !s1_valid || !s2_valid || out_ready;
   assign in_fire  = in_valid && in_ready;

   // Result computation from the stage-1 operands. The subtract is done one
   // bit wider so the top bit directly gives the unsigned borrow.
   always_comb begin
      sum_ext   = {1'b0, s1_a} + {1'b0, s1_b};
      diff_ext  = {1'b0, s1_a} - {1'b0, s1_b};
      res_c     = '0;
      res_carry = 1'b0;
      res_ovf   = 1'b0;
      res_err   = 1'b0;
      case (s1_op)
         OP_AND: res_c = s1_a & s1_b;
         OP_OR:  res_c = s1_a | s1_b;
         OP_ADD: begin
            res_c     = sum_ext[WIDTH-1:0];
            res_carry = sum_ext[WIDTH];
            res_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                        (res_c[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_SUB: begin
            res_c     = diff_ext[WIDTH-1:0];
            res_carry = diff_ext[WIDTH];
            res_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                        (res_c[WIDTH-1] != s1_a[WIDTH-1]);
         end
         default: res_err = 1'b1;
      endcase
      // Illegal opcodes report an all-zero flag nibble, so zero/negative
      // are only formed for legal operations.
      if (res_err) begin
         res_flags = 4'b0000;
      end else begin
         res_flags = {res_carry, res_ovf, (res_c == '0), res_c[WIDTH-1]};
      end
   end

   // Stage 1: operand capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= 3'b000;
      end else if (s1_load) begin
         s1_valid <= in_fire;
         if (in_fire) begin
            s1_a  <= A;
            s1_b  <= B;
            s1_op <= opmode;
         end
      end
   end

   // Stage 2: result capture. The outputs only change when advancing, so a
   // stalled result stays stable until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_c     <= '0;
         s2_flags <= 4'b0000;
         s2_err   <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_c     <= res_c;
            s2_flags <= res_flags;
            s2_err   <= res_err;
         end
      end
   end

   assign out_valid = s2_valid;
   assign C         = s2_c;
   assign flags     = s2_flags;
   assign err_op    = s2_err;

endmodule

// File: tb/tb_mtm_alu_core_seq.sv
// ---------------------------------------------------------------------------
// tb_mtm_alu_core_seq
// Directed self-checking bench for mtm_alu_core_seq. A 32-bit and an 8-bit
// instance share clock and reset. Inputs are driven and outputs sampled 1ns
// after the rising edge. An operand set driven before edge N is accepted at
// edge N and its result is visible after edge N+1.
// ---------------------------------------------------------------------------
module tb_mtm_alu_core_seq;

   logic        clk;
   logic        rst;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  opmode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] c;
   logic [3:0]  flags;
   logic        err_op;

   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic [2:0]  opmode8;
   logic        out_valid8;
   logic        out_ready8;
   logic [7:0]  c8;
   logic [3:0]  flags8;
   logic        err_op8;

   int checks;
   int failures;

   mtm_alu_core_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .opmode(opmode),
      .out_valid(out_valid), .out_ready(out_ready),
      .C(c), .flags(flags), .err_op(err_op)
   );

   mtm_alu_core_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .A(a8), .B(b8), .opmode(opmode8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .C(c8), .flags(flags8), .err_op(err_op8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the bench always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] da, input logic [31:0] db,
                        input logic [2:0] op);
      in_valid = v;
      a        = da;
      b        = db;
      opmode   = op;
   endtask

   // Push one operand set into the 32-bit instance and capture what the
   // outputs show one edge and two edges later.
   task automatic run32(input logic [31:0] da, input logic [31:0] db, input logic [2:0] op,
                        output logic early_v, output logic v, output logic [31:0] rc,
                        output logic [3:0] rf, output logic re);
      drive(1'b1, da, db, op);
      tick();
      drive(1'b0, 32'h0, 32'h0, 3'b000);
      early_v = out_valid;
      tick();
      v  = out_valid;
      rc = c;
      rf = flags;
      re = err_op;
   endtask

   task automatic run8(input logic [7:0] da, input logic [7:0] db, input logic [2:0] op,
                       output logic v, output logic [7:0] rc, output logic [3:0] rf,
                       output logic re);
      in_valid8 = 1'b1;
      a8        = da;
      b8        = db;
      opmode8   = op;
      tick();
      in_valid8 = 1'b0;
      tick();
      v  = out_valid8;
      rc = c8;
      rf = flags8;
      re = err_op8;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 32'h1234, 32'h1, 3'b100);
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || c !== 32'h0 || flags !== 4'h0 || err_op !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got v=%b c=%h f=%b e=%b, required 0/0/0/0",
                  out_valid, c, flags, err_op);
      end
      checks++;
      if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_in_ready: got %b/%b, required 1/1", in_ready, in_ready8);
      end
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 3'b000);
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_no_accept: got out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_add32();
      logic ev, v, e;
      logic [31:0] rc;
      logic [3:0] rf;
      run32(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, ev, v, rc, rf, e);
      checks++;
      if (ev !== 1'b0) begin
         failures++;
         $display("[TB] FAIL latency_early: got out_valid=%b after one edge, required 0", ev);
      end
      checks++;
      if (v !== 1'b1 || rc !== 32'h0 || rf !== 4'b1010 || e !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_carry_zero: got v=%b c=%h f=%b e=%b, required 1/00000000/1010/0",
                  v, rc, rf, e);
      end
      run32(32'h7FFF_FFFF, 32'h0000_0001, 3'b100, ev, v, rc, rf, e);
      checks++;
      if (v !== 1'b1 || rc !== 32'h8000_0000 || rf !== 4'b0101 || e !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_overflow: got v=%b c=%h f=%b e=%b, required 1/80000000/0101/0",
                  v, rc, rf, e);
      end
      run32(32'h0000_0000, 32'h0000_0001, 3'b101, ev, v, rc, rf, e);
      checks++;
      if (v !== 1'b1 || rc !== 32'hFFFF_FFFF || rf !== 4'b1001 || e !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sub_borrow: got v=%b c=%h f=%b e=%b, required 1/ffffffff/1001/0",
                  v, rc, rf, e);
      end
   endtask

   task automatic test_width8();
      logic v, e;
      logic [7:0] rc;
      logic [3:0] rf;
      run8(8'h80, 8'h01, 3'b101, v, rc, rf, e);
      checks++;
      if (v !== 1'b1 || rc !== 8'h7F || rf !== 4'b0100 || e !== 1'b0) begin
         failures++;
         $display("[TB] FAIL w8_sub_overflow: got v=%b c=%h f=%b e=%b, required 1/7f/0100/0",
                  v, rc, rf, e);
      end
      run8(8'hF0, 8'h0F, 3'b000, v, rc, rf, e);
      checks++;
      if (v !== 1'b1 || rc !== 8'h00 || rf !== 4'b0010 || e !== 1'b0) begin
         failures++;
         $display("[TB] FAIL w8_and_zero: got v=%b c=%h f=%b e=%b, required 1/00/0010/0",
                  v, rc, rf, e);
      end
   endtask

   task automatic test_illegal();
      logic ev, v, e;
      logic [31:0] rc;
      logic [3:0] rf;
      run32(32'd5, 32'd3, 3'b010, ev, v, rc, rf, e);
      checks++;
      if (v !== 1'b1 || rc !== 32'h0 || rf !== 4'b0000 || e !== 1'b1) begin
         failures++;
         $display("[TB] FAIL illegal_op: got v=%b c=%h f=%b e=%b, required 1/00000000/0000/1",
                  v, rc, rf, e);
      end
      run32(32'd5, 32'd3, 3'b001, ev, v, rc, rf, e);
      checks++;
      if (v !== 1'b1 || rc !== 32'd7 || rf !== 4'b0000 || e !== 1'b0) begin
         failures++;
         $display("[TB] FAIL or_after_illegal: got v=%b c=%h f=%b e=%b, required 1/00000007/0000/0",
                  v, rc, rf, e);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      drive(1'b1, 32'd10, 32'd20, 3'b100);
      tick();
      drive(1'b1, 32'd5, 32'd5, 3'b101);
      tick();
      checks++;
      if (out_valid !== 1'b1 || c !== 32'd30 || flags !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL b2b_first: got v=%b c=%h f=%b, required 1/0000001e/0000",
                  out_valid, c, flags);
      end
      drive(1'b1, 32'h8000_0000, 32'h1, 3'b001);
      tick();
      checks++;
      if (out_valid !== 1'b1 || c !== 32'h0 || flags !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL b2b_second: got v=%b c=%h f=%b, required 1/00000000/0010",
                  out_valid, c, flags);
      end
      drive(1'b0, 32'h0, 32'h0, 3'b000);
      tick();
      checks++;
      if (out_valid !== 1'b1 || c !== 32'h8000_0001 || flags !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL b2b_third: got v=%b c=%h f=%b, required 1/80000001/0001",
                  out_valid, c, flags);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_drain: got out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b000);
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_ready_one: got in_ready=%b, required 1", in_ready);
      end
      drive(1'b1, 32'd1, 32'd2, 3'b100);
      tick();
      drive(1'b1, 32'd3, 32'd5, 3'b101);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || c !== 32'h0F00_0F00) begin
         failures++;
         $display("[TB] FAIL bp_full: got rdy=%b v=%b c=%h, required 0/1/0f000f00",
                  in_ready, out_valid, c);
      end
      tick();
      checks++;
      if (in_ready !== 1'b0 || c !== 32'h0F00_0F00 || flags !== 4'b0000 || err_op !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_hold: got rdy=%b c=%h f=%b e=%b, required 0/0f000f00/0000/0",
                  in_ready, c, flags, err_op);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_release_ready: got in_ready=%b, required 1", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || c !== 32'd3 || flags !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL bp_second: got v=%b c=%h f=%b, required 1/00000003/0000",
                  out_valid, c, flags);
      end
      drive(1'b1, 32'h0, 32'h0, 3'b001);
      tick();
      checks++;
      if (out_valid !== 1'b1 || c !== 32'hFFFF_FFFE || flags !== 4'b1001) begin
         failures++;
         $display("[TB] FAIL bp_third: got v=%b c=%h f=%b, required 1/fffffffe/1001",
                  out_valid, c, flags);
      end
      drive(1'b0, 32'h0, 32'h0, 3'b000);
      tick();
      checks++;
      if (out_valid !== 1'b1 || c !== 32'h0 || flags !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL bp_fourth: got v=%b c=%h f=%b, required 1/00000000/0010",
                  out_valid, c, flags);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_drain: got out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      drive(1'b1, 32'd100, 32'd1, 3'b100);
      tick();
      drive(1'b1, 32'd200, 32'd1, 3'b100);
      tick();
      checks++;
      if (out_valid !== 1'b1 || c !== 32'd101) begin
         failures++;
         $display("[TB] FAIL mid_before_reset: got v=%b c=%h, required 1/00000065", out_valid, c);
      end
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 3'b000);
      tick();
      checks++;
      if (out_valid !== 1'b0 || c !== 32'h0 || flags !== 4'h0) begin
         failures++;
         $display("[TB] FAIL mid_reset: got v=%b c=%h f=%b, required 0/00000000/0000",
                  out_valid, c, flags);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_discard: got out_valid=%b, required 0", out_valid);
      end
      drive(1'b1, 32'd7, 32'd8, 3'b100);
      tick();
      drive(1'b0, 32'h0, 32'h0, 3'b000);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_post_early: got out_valid=%b, required 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || c !== 32'd15 || flags !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL mid_post_result: got v=%b c=%h f=%b, required 1/0000000f/0000",
                  out_valid, c, flags);
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      out_ready  = 1'b1;
      out_ready8 = 1'b1;
      in_valid8  = 1'b0;
      a8         = 8'h0;
      b8         = 8'h0;
      opmode8    = 3'b000;
      drive(1'b0, 32'h0, 32'h0, 3'b000);
      #1;
      $display("[TB] starting mtm_alu_core_seq bench");
      test_reset();
      test_add32();
      test_width8();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mtm_alu_core_seq.md
MTM_ALU_CORE_SEQ -- requirements
Module: mtm_alu_core_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 8..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand set A/B/opmode present this cycle.
REQ-005 in_ready  output  1  block accepts operands this cycle; transfer when in_valid && in_ready.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 opmode  input  3  000 AND, 001 OR, 100 ADD, 101 SUB; all other codes illegal.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result; transfer when out_valid && out_ready.
REQ-011 C  output  WIDTH  result.
REQ-012 flags  output  4  {carry, overflow, zero, negative}.
REQ-013 err_op  output  1  result belongs to a transaction with illegal opmode.

Function
REQ-014 Two-stage pipeline SHALL be used: S1 registers A, B, opmode; S2 registers C, flags, err_op.
REQ-015 Latency SHALL be exactly 2 cycles from accepting edge to out_valid high, with out_ready held high.
REQ-016 Throughput SHALL be one transaction per cycle with out_ready held high.
REQ-017 S2 SHALL load when S2 is empty or out_ready is high; S1 SHALL advance under the same condition.
REQ-018 in_ready SHALL equal !s1_valid || !s2_valid || out_ready (combinational, no dependence on in_valid).
REQ-019 While out_valid && !out_ready, C, flags and err_op SHALL hold stable.
REQ-020 Transactions SHALL never be dropped, duplicated or reordered; max 2 in flight.
REQ-021 AND/OR: C = A&B / A|B; carry = 0, overflow = 0.
REQ-022 ADD: C = (A+B) mod 2^WIDTH; carry = bit WIDTH of the WIDTH+1-bit unsigned sum.
REQ-023 ADD overflow SHALL be 1 when A and B have equal MSBs and C's MSB differs.
REQ-024 SUB: C = (A-B) mod 2^WIDTH; carry = 1 when A < B unsigned (borrow).
REQ-025 SUB overflow SHALL be 1 when A and B MSBs differ and C's MSB differs from A's.
REQ-026 zero SHALL be 1 iff C == 0; negative SHALL equal C[WIDTH-1]; both apply to all legal ops.
REQ-027 Illegal opmode: C = 0, flags = 4'b0000, err_op = 1; the transaction still occupies a slot and completes normally.
REQ-028 err_op SHALL be 0 for legal opmodes.
REQ-029 Simultaneous output pop and input push with both stages full SHALL shift the pipeline with no bubble.

Reset
REQ-030 With rst high at a rising edge, s1_valid and s2_valid SHALL clear, emptying both stages.
REQ-031 During and after reset, out_valid = 0, C = 0, flags = 0, err_op = 0 and in_ready = 1.
REQ-032 Reset mid-operation SHALL discard all in-flight transactions; no output SHALL appear for them.
REQ-033 in_valid asserted while rst is high SHALL NOT be accepted.

Verification
REQ-034 WIDTH=32, ADD A=0xFFFFFFFF, B=0x00000001, out_ready=1 -> 2 cycles later C=0, flags=4'b1010 (carry, zero), err_op=0.
REQ-035 WIDTH=32, ADD A=0x7FFFFFFF, B=1 -> C=0x80000000, flags=4'b0101; SUB A=0, B=1 -> C=0xFFFFFFFF, flags=4'b1001.
REQ-036 WIDTH=8, SUB A=0x80, B=0x01 -> C=0x7F, flags=4'b0100; AND A=0xF0, B=0x0F -> C=0x00, flags=4'b0010.
REQ-037 opmode=3'b010, A=5, B=3 -> C=0, flags=0, err_op=1; the next legal op (OR 5|3) -> C=7, err_op=0.
REQ-038 Back-pressure: push 4 back-to-back ops with out_ready=0 -> in_ready drops after 2 accepts, output holds first result; release out_ready -> 4 results in order, one per cycle.
REQ-039 Reset mid-stream with 2 in flight -> out_valid=0 next cycle; the first post-reset op appears 2 cycles after acceptance.
